// File: rtl/barrel_shifter_pipe_if.sv
// Stream bus for barrel_shifter_pipe: operand, amount and mode in; shifted result out.
interface barrel_shifter_pipe_if #(
   parameter int unsigned WIDTH = 196,
   parameter int unsigned AMT_W = 8
);
   logic             i_valid;
   logic             o_ready;
   logic [WIDTH-1:0] i_data;
   logic [AMT_W-1:0] i_amt;
   logic [1:0]       i_mode;
   logic             o_valid;
   logic             i_ready;
   logic [WIDTH-1:0] o_data;

   modport slave (
      input  i_valid, i_data, i_amt, i_mode, i_ready,
      output o_ready, o_valid, o_data
   );

   modport master (
      output i_valid, i_data, i_amt, i_mode, i_ready,
      input  o_ready, o_valid, o_data
   );
endinterface

// File: rtl/barrel_shifter_pipe.sv
// Pipelined multi-mode barrel shifter (LSR/ASR/LSL/ROR): AMT_W mux levels split into LAT
// register ranks under a single global stall.
module barrel_shifter_pipe #(
   parameter int unsigned WIDTH = 196,
   parameter int unsigned AMT_W = 8,
   parameter int unsigned LAT   = 2
) (
   input logic                  i_clk,
   input logic                  i_rst_n,
   barrel_shifter_pipe_if.slave bus
);
   localparam logic [1:0] MODE_LSR = 2'b00;
   localparam logic [1:0] MODE_ASR = 2'b01;
   localparam logic [1:0] MODE_LSL = 2'b10;
   localparam logic [1:0] MODE_ROR = 2'b11;

   // The first AMT_W mod LAT groups take one extra level.
   localparam int unsigned GRP_BIG = AMT_W % LAT;
   localparam int unsigned GRP_HI  = (AMT_W + LAT - 1) / LAT;
   localparam int unsigned GRP_LO  = AMT_W / LAT;

   localparam logic [WIDTH-1:0] ONES = '1;

   function automatic int unsigned grp_first(input int unsigned g);
      return (g < GRP_BIG) ? g * GRP_HI : GRP_BIG * GRP_HI + (g - GRP_BIG) * GRP_LO;
   endfunction

   logic advance;
   logic out_valid;

   for (genvar g = 0; g < LAT; g++) begin : g_grp
      localparam int unsigned FIRST = grp_first(g);
      localparam int unsigned NLVL  = (g < GRP_BIG) ? GRP_HI : GRP_LO;
      localparam int unsigned REM_W = AMT_W - FIRST;

      logic             in_valid;
      logic [WIDTH-1:0] in_data;
      logic [REM_W-1:0] in_amt;
      logic [1:0]       in_mode;
      logic             in_sign;
      logic             r_valid;
      logic [WIDTH-1:0] r_data;

      if (g == 0) begin : g_src
         assign in_valid = bus.i_valid;
         assign in_data  = bus.i_data;
         assign in_amt   = bus.i_amt;
         assign in_mode  = bus.i_mode;
         assign in_sign  = bus.i_data[WIDTH-1];
      end else begin : g_src
         assign in_valid = g_grp[g-1].r_valid;
         assign in_data  = g_grp[g-1].r_data;
         assign in_amt   = g_grp[g-1].g_fwd.r_amt;
         assign in_mode  = g_grp[g-1].g_fwd.r_mode;
         assign in_sign  = g_grp[g-1].g_fwd.r_sign;
      end

      // Level k moves the word by 2^k; rotation is taken modulo WIDTH so the ring wraps correctly.
      for (genvar j = 0; j < NLVL; j++) begin : g_lvl
         localparam int unsigned SH  = 2 ** (FIRST + j);
         localparam int unsigned ROT = SH % WIDTH;

         logic [WIDTH-1:0] d;
         logic [WIDTH-1:0] q;
         logic [WIDTH-1:0] rot;

         if (j == 0) begin : g_in
            assign d = in_data;
         end else begin : g_in
            assign d = g_lvl[j-1].q;
         end

         if (ROT == 0) begin : g_rot
            assign rot = d;
         end else begin : g_rot
            assign rot = (d >> ROT) | (d << (WIDTH - ROT));
         end

         always_comb begin
            q = d;
            if (in_amt[j]) begin
               case (in_mode)
                  MODE_LSR: q = d >> SH;
                  MODE_ASR: q = (d >> SH) | (in_sign ? ~(ONES >> SH) : '0);
                  MODE_LSL: q = d << SH;
                  MODE_ROR: q = rot;
               endcase
            end
         end
      end

      always_ff @(posedge i_clk) begin
         if (!i_rst_n) begin
            r_valid <= 1'b0;
         end else if (advance) begin
            r_valid <= in_valid;
         end
      end

      if (g < LAT - 1) begin : g_fwd
         localparam int unsigned NXT_W = REM_W - NLVL;

         logic [NXT_W-1:0] r_amt;
         logic [1:0]       r_mode;
         logic             r_sign;

         always_ff @(posedge i_clk) begin
            if (advance) begin
               r_data <= g_lvl[NLVL-1].q;
               r_amt  <= in_amt[REM_W-1:NLVL];
               r_mode <= in_mode;
               r_sign <= in_sign;
            end
         end
      end else begin : g_last
         // Output rank clears its data so a reset never shows a stale result.
         always_ff @(posedge i_clk) begin
            if (!i_rst_n) begin
               r_data <= '0;
            end else if (advance) begin
               r_data <= g_lvl[NLVL-1].q;
            end
         end
      end
   end

   assign out_valid   = g_grp[LAT-1].r_valid;
   assign advance     = !out_valid || bus.i_ready;
   assign bus.o_ready = advance;
   assign bus.o_valid = out_valid;
   assign bus.o_data  = g_grp[LAT-1].r_data;
endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Randomized bench for barrel_shifter_pipe against a per-bit reference model, plus a parameter sweep.
module tb_barrel_shifter_pipe;
   localparam int unsigned MW = 196;
   localparam int unsigned MA = 8;
   localparam int unsigned ML = 2;
   localparam int N_SWEEP    = 10000;
   localparam int CYC_BUDGET = 40000;

   localparam logic [255:0] ONE     = 256'd1;
   localparam logic [255:0] ONES196 = (256'd1 << 196) - 256'd1;

   typedef struct {
      logic [255:0] exp;
      int           acc;
      int           snap;
   } item_t;

   typedef struct {
      logic [255:0] d;
      int unsigned  a;
      logic [1:0]   m;
      logic [255:0] exp;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Result bit i taken directly from the operand bit it should come from.
   function automatic logic [255:0] ref_shift(input int unsigned w, input logic [255:0] d,
                                              input int unsigned amt, input logic [1:0] mode);
      logic [255:0] r;
      r = '0;
      for (int unsigned i = 0; i < w; i++) begin
         case (mode)
            2'b00:   r[i] = (i + amt < w) ? d[i + amt] : 1'b0;
            2'b01:   r[i] = (i + amt < w) ? d[i + amt] : d[w - 1];
            2'b10:   r[i] = (i >= amt) ? d[i - amt] : 1'b0;
            default: r[i] = d[(i + amt) % w];
         endcase
      end
      return r;
   endfunction

   function automatic logic [255:0] rand_word();
      return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
   endfunction

   // ---------------- main instance: WIDTH=196, AMT_W=8, LAT=2 ----------------
   logic m_rst_n;
   barrel_shifter_pipe_if #(.WIDTH(MW), .AMT_W(MA)) mif ();
   barrel_shifter_pipe #(.WIDTH(MW), .AMT_W(MA), .LAT(ML)) u_dut (
      .i_clk   (clk),
      .i_rst_n (m_rst_n),
      .bus     (mif.slave)
   );

   item_t mq[$];
   int    m_cyc    = 0;
   int    m_stalls = 0;

   // One clock of the main instance: drive, then compare against the queue model.
   task automatic mstep(input bit v, input logic [255:0] d, input int unsigned a, input logic [1:0] m,
                        input bit rdy, input logic [255:0] exp, output bit acc);
      bit ev;
      @(negedge clk);
      m_cyc++;
      mif.i_valid = v;
      mif.i_data  = MW'(d);
      mif.i_amt   = MA'(a);
      mif.i_mode  = m;
      mif.i_ready = rdy;
      #1;
      ev = (mq.size() > 0) && ((m_cyc - mq[0].acc - (m_stalls - mq[0].snap)) >= int'(ML));
      check("valid", 256'(mif.o_valid), 256'(ev));
      check("ready", 256'(mif.o_ready), 256'(!ev || rdy));
      if (ev) check("data", 256'(mif.o_data), mq[0].exp);
      if (ev && rdy) void'(mq.pop_front());
      acc = v && (!ev || rdy);
      if (acc) mq.push_back('{exp, m_cyc, m_stalls});
      if (ev && !rdy) m_stalls++;
   endtask

   task automatic mrand(input bit v, input bit rdy, output bit acc);
      logic [255:0] d;
      int unsigned  a;
      logic [1:0]   m;
      d = rand_word();
      a = $urandom_range(0, 255);
      m = 2'($urandom_range(0, 3));
      mstep(v, d, a, m, rdy, ref_shift(MW, d, a, m), acc);
   endtask

   initial begin
      vec_t         dv[$];
      logic [255:0] bw_d [10];
      int unsigned  bw_a [10];
      logic [1:0]   bw_m [10];
      logic [255:0] r;
      bit           acc;
      int           sent;

      m_rst_n     = 1'b0;
      mif.i_valid = 1'b1;
      mif.i_data  = MW'(rand_word());
      mif.i_amt   = 8'd3;
      mif.i_mode  = 2'b00;
      mif.i_ready = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check("rst0_valid", 256'(mif.o_valid), 256'(0));
      check("rst0_ready", 256'(mif.o_ready), 256'(1));
      check("rst0_data", 256'(mif.o_data), 256'(0));
      m_rst_n     = 1'b1;
      mif.i_valid = 1'b0;
      repeat (3) mstep(1'b0, '0, 0, 2'b00, 1'b1, '0, acc);

      // Directed boundary vectors with hand-derived results.
      dv.push_back('{ONE, 195, 2'b10, ONE << 195});
      dv.push_back('{ONE, 196, 2'b10, 256'd0});
      dv.push_back('{ONE << 195, 195, 2'b00, ONE});
      dv.push_back('{ONE << 195, 200, 2'b01, ONES196});
      dv.push_back('{256'hF0, 4, 2'b01, 256'h0F});
      dv.push_back('{ONE, 197, 2'b11, ONE << 195});
      dv.push_back('{ONE, 196, 2'b11, ONE});
      dv.push_back('{256'd3, 1, 2'b11, ONE | (ONE << 195)});
      dv.push_back('{ONES196, 1, 2'b10, ONES196 ^ ONE});
      dv.push_back('{ONES196, 255, 2'b00, 256'd0});
      dv.push_back('{ONES196, 1, 2'b01, ONES196});
      dv.push_back('{ONE << 194, 3, 2'b01, ONE << 191});
      for (int k = 0; k < 4; k++) begin
         r = rand_word() & ONES196;
         dv.push_back('{r, 0, 2'(k), r});
      end
      foreach (dv[i]) mstep(1'b1, dv[i].d, dv[i].a, dv[i].m, 1'b1, dv[i].exp, acc);
      repeat (ML + 2) mstep(1'b0, '0, 0, 2'b00, 1'b1, '0, acc);
      check("dir_drain", 256'(mq.size()), 256'(0));

      // Ten words with a three-cycle downstream stall in the middle.
      for (int i = 0; i < 10; i++) begin
         bw_d[i] = rand_word();
         bw_a[i] = $urandom_range(0, 255);
         bw_m[i] = 2'($urandom_range(0, 3));
      end
      sent = 0;
      for (int k = 0; k < 40 && (sent < 10 || mq.size() > 0); k++) begin
         int idx;
         idx = (sent < 10) ? sent : 9;
         mstep(sent < 10, bw_d[idx], bw_a[idx], bw_m[idx], !(k >= 4 && k <= 6),
               ref_shift(MW, bw_d[idx], bw_a[idx], bw_m[idx]), acc);
         if (acc) sent++;
      end
      check("bp_sent", 256'(sent), 256'(10));
      check("bp_drain", 256'(mq.size()), 256'(0));

      // One-cycle reset pulse with two words in flight; words offered in that cycle are dropped.
      mrand(1'b1, 1'b1, acc);
      mrand(1'b1, 1'b1, acc);
      @(negedge clk);
      m_cyc++;
      m_rst_n     = 1'b0;
      mif.i_valid = 1'b1;
      mif.i_data  = MW'(rand_word());
      mif.i_ready = 1'b0;
      @(negedge clk);
      m_cyc++;
      m_rst_n     = 1'b1;
      mif.i_valid = 1'b0;
      #1;
      check("rst_valid", 256'(mif.o_valid), 256'(0));
      check("rst_data", 256'(mif.o_data), 256'(0));
      check("rst_ready", 256'(mif.o_ready), 256'(1));
      mq.delete();
      repeat (4) mstep(1'b0, '0, 0, 2'b00, 1'b1, '0, acc);
      mrand(1'b1, 1'b1, acc);
      repeat (ML + 2) mstep(1'b0, '0, 0, 2'b00, 1'b1, '0, acc);
      check("rst_fresh_drain", 256'(mq.size()), 256'(0));

      // Random traffic with random gaps and random backpressure.
      for (int k = 0; k < 800; k++) mrand($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, acc);
      for (int k = 0; k < 50 && mq.size() > 0; k++) mstep(1'b0, '0, 0, 2'b00, 1'b1, '0, acc);
      check("rand_drain", 256'(mq.size()), 256'(0));

      wait (g_sw[0].done && g_sw[1].done && g_sw[2].done);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog no_finish");
      $fatal(1, "watchdog");
   end

   // ---------------- parameter sweep instances ----------------
   for (genvar c = 0; c < 3; c++) begin : g_sw
      localparam int unsigned W = (c == 2) ? 64 : 196;
      localparam int unsigned A = (c == 2) ? 6 : 8;
      localparam int unsigned L = (c == 0) ? 1 : (c == 1) ? 8 : 3;

      logic rst_n;
      bit   done = 1'b0;

      barrel_shifter_pipe_if #(.WIDTH(W), .AMT_W(A)) sif ();
      barrel_shifter_pipe #(.WIDTH(W), .AMT_W(A), .LAT(L)) u_dut (
         .i_clk   (clk),
         .i_rst_n (rst_n),
         .bus     (sif.slave)
      );

      initial begin
         item_t        q[$];
         int           cyc;
         int           stalls;
         int           sent;
         bit           ev;
         bit           rdy;
         logic [255:0] d;
         int unsigned  a;
         logic [1:0]   m;

         cyc         = 0;
         stalls      = 0;
         sent        = 0;
         rst_n       = 1'b0;
         sif.i_valid = 1'b0;
         sif.i_ready = 1'b1;
         sif.i_data  = '0;
         sif.i_amt   = '0;
         sif.i_mode  = '0;
         repeat (3) @(negedge clk);
         rst_n = 1'b1;
         while ((sent < N_SWEEP || q.size() > 0) && cyc < CYC_BUDGET) begin
            @(negedge clk);
            cyc++;
            d = rand_word();
            a = $urandom_range(0, (1 << A) - 1);
            m = 2'($urandom_range(0, 3));
            rdy = (sent >= N_SWEEP) || ($urandom_range(0, 7) != 0);
            sif.i_valid = (sent < N_SWEEP) && ($urandom_range(0, 7) != 0);
            sif.i_data  = W'(d);
            sif.i_amt   = A'(a);
            sif.i_mode  = m;
            sif.i_ready = rdy;
            #1;
            ev = (q.size() > 0) && ((cyc - q[0].acc - (stalls - q[0].snap)) >= int'(L));
            check($sformatf("sw%0d_valid", c), 256'(sif.o_valid), 256'(ev));
            check($sformatf("sw%0d_ready", c), 256'(sif.o_ready), 256'(!ev || rdy));
            if (ev) check($sformatf("sw%0d_data", c), 256'(sif.o_data), q[0].exp);
            if (ev && rdy) void'(q.pop_front());
            if (sif.i_valid && (!ev || rdy)) begin
               q.push_back('{ref_shift(W, d, a, m), cyc, stalls});
               sent++;
            end
            if (ev && !rdy) stalls++;
         end
         check($sformatf("sw%0d_sent", c), 256'(sent), 256'(N_SWEEP));
         check($sformatf("sw%0d_drain", c), 256'(q.size()), 256'(0));
         done = 1'b1;
      end
   end
endmodule
